// File: rtl/burst_tx_pkg.sv
// rtl/burst_tx_pkg.sv - shared types and field positions for the burst transmit framer
package burst_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int I_MSB      = 31;
    localparam int I_LSB      = 16;
    localparam int Q_MSB      = 15;
    localparam int Q_LSB      = 0;
    localparam int RAMP_STEPS = 4;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/iq_ramp_shift.sv
// rtl/iq_ramp_shift.sv - arithmetic right shift of both IQ halves by a 2-bit amount
module iq_ramp_shift
    import burst_tx_pkg::*;
(
    input  logic [31:0] iq_i,
    input  logic [1:0]  shift_i,
    output logic [31:0] iq_o
);

    logic signed [15:0] i_s;
    logic signed [15:0] q_s;
    logic signed [15:0] i_sh;
    logic signed [15:0] q_sh;

    assign i_s  = iq_i[I_MSB:I_LSB];
    assign q_s  = iq_i[Q_MSB:Q_LSB];
    assign i_sh = i_s >>> shift_i;
    assign q_sh = q_s >>> shift_i;
    assign iq_o = {i_sh, q_sh};

endmodule

// File: rtl/burst_tx_framer.sv
// rtl/burst_tx_framer.sv - IQ packet to tick-paced sample framer with guard gap; BURST_TX_RAMP_EN adds ramp-in
module burst_tx_framer
    import burst_tx_pkg::*;
#(
    parameter int GAP_LEN  = 96,
    parameter int LEAD_LEN = 0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sample_tick_in,
    input  logic [31:0] s_data_in,
    input  logic        s_valid_in,
    input  logic        s_last_in,
    output logic        s_ready_out,
    output logic [31:0] signal_data_out,
    output logic        signal_valid_out,
    output logic        busy_out,
    output logic        underrun_out
);

    localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);
    localparam logic [15:0] LEAD_LAST = 16'(LEAD_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        under_q, under_d;
    logic [31:0] burst_sample;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;

`ifdef BURST_TX_RAMP_EN
    logic [1:0] ramp_shift;

    // Burst index 0..3 maps to shift 3..0; underrun ticks advance the index too.
    assign ramp_shift = (cnt_q < 16'(RAMP_STEPS)) ? 2'(16'(RAMP_STEPS - 1) - cnt_q) : 2'd0;

    iq_ramp_shift u_ramp (
        .iq_i    (s_data_in),
        .shift_i (ramp_shift),
        .iq_o    (burst_sample)
    );
`else
    assign burst_sample = s_data_in;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid_in) state_d = (LEAD_LEN > 0) ? LEAD : BURST;
            LEAD:    if (sample_tick_in && cnt_q == LEAD_LAST) state_d = BURST;
            BURST:   if (sample_tick_in && s_valid_in && s_last_in) state_d = GAP;
            GAP:     if (sample_tick_in && cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = sample_tick_in;
        data_d  = data_q;
        under_d = 1'b0;
        cnt_d   = cnt_q;
        if (sample_tick_in) begin
            data_d = '0;
        end
        case (state_q)
            IDLE: cnt_d = '0;
            LEAD: if (sample_tick_in) cnt_d = (state_d != LEAD) ? 16'd0 : cnt_inc;
            BURST: begin
                if (sample_tick_in) begin
                    if (s_valid_in) begin
                        data_d = burst_sample;
                    end else begin
                        under_d = 1'b1;
                    end
                    cnt_d = (state_d == GAP) ? 16'd0 : cnt_inc;
                end
            end
            GAP:  if (sample_tick_in) cnt_d = (state_d == IDLE) ? 16'd0 : cnt_inc;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            under_q <= under_d;
        end
    end

    assign s_ready_out      = (state_q == BURST) && sample_tick_in;
    assign busy_out         = (state_q != IDLE);
    assign signal_data_out  = data_q;
    assign signal_valid_out = valid_q;
    assign underrun_out     = under_q;

endmodule

// File: tb/tb_burst_tx_framer.sv
// tb/tb_burst_tx_framer.sv - randomized self-checking bench for burst_tx_framer against a packet-level model
module tb_burst_tx_framer;

    localparam int GAP_LEN = 96;
`ifdef BURST_TX_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        tick;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] sig_data;
    logic        sig_valid;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] pkt[$];

    burst_tx_framer #(.GAP_LEN(GAP_LEN), .LEAD_LEN(0)) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .sample_tick_in   (tick),
        .s_data_in        (s_data),
        .s_valid_in       (s_valid),
        .s_last_in        (s_last),
        .s_ready_out      (s_ready),
        .signal_data_out  (sig_data),
        .signal_valid_out (sig_valid),
        .busy_out         (busy),
        .underrun_out     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output for the idx-th tick of a burst: ramp scales the first four by 1/8,1/4,1/2,1.
    function automatic logic [31:0] model_out(input logic [31:0] d, input int idx);
        logic signed [15:0] i_v;
        logic signed [15:0] q_v;
        i_v = d[31:16];
        q_v = d[15:0];
        if (RAMP_ON && idx < 4) begin
            i_v = i_v >>> (3 - idx);
            q_v = q_v >>> (3 - idx);
        end
        return {i_v, q_v};
    endfunction

    // One sample period of four clocks; the tick lands on the last one.
    task automatic tick_cycle(input logic v, input logic [31:0] d, input logic l,
                              output logic rdy, output logic ov, output logic [31:0] od,
                              output logic ou, output logic ob, output logic quiet);
        @(posedge clk);
        #1 quiet = ~sig_valid & ~underrun;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        tick    = 1'b1;
        #1 rdy  = s_ready;
        @(posedge clk);
        #1;
        ov   = sig_valid;
        od   = sig_data;
        ou   = underrun;
        ob   = busy;
        tick = 1'b0;
    endtask

    task automatic run_packet(input string name, input int stall_pos, input int stall_n,
                              input bit hold_next);
        int          kind[$];
        logic [31:0] exp_d[$];
        bit          exp_u[$];
        bit          exp_r[$];
        bit          exp_b[$];
        int          idx;
        int          pi;
        logic        v, l, rdy, ov, ou, ob, quiet;
        logic [31:0] d, od;

        idx = 0;
        for (int i = 0; i < pkt.size(); i++) begin
            if (i == stall_pos) begin
                for (int s = 0; s < stall_n; s++) begin
                    kind.push_back(0); exp_d.push_back(32'd0); exp_u.push_back(1'b1);
                    exp_r.push_back(1'b1); exp_b.push_back(1'b1); idx++;
                end
            end
            kind.push_back(1); exp_d.push_back(model_out(pkt[i], idx)); exp_u.push_back(1'b0);
            exp_r.push_back(1'b1); exp_b.push_back(1'b1); idx++;
        end
        for (int g = 0; g < GAP_LEN; g++) begin
            kind.push_back(2); exp_d.push_back(32'd0); exp_u.push_back(1'b0);
            exp_r.push_back(1'b0); exp_b.push_back(g != GAP_LEN - 1);
        end

        s_valid = 1'b1;
        s_data  = pkt[0];
        s_last  = (pkt.size() == 1);
        pi = 0;
        for (int k = 0; k < kind.size(); k++) begin
            if (kind[k] == 0) begin
                v = 1'b0; d = 32'h1234_5678; l = 1'b0;
            end else if (kind[k] == 1) begin
                v = 1'b1; d = pkt[pi]; l = (pi == pkt.size() - 1); pi++;
            end else begin
                v = hold_next; d = 32'hDEAD_BEEF; l = 1'b0;
            end
            tick_cycle(v, d, l, rdy, ov, od, ou, ob, quiet);
            n_checks += 6;
            if (quiet !== 1'b1) $display("FAIL %s[%0d] no_tick_quiet got 0 want 1", name, k); else n_pass++;
            if (rdy !== exp_r[k]) $display("FAIL %s[%0d] s_ready got %b want %b", name, k, rdy, exp_r[k]); else n_pass++;
            if (ov !== 1'b1) $display("FAIL %s[%0d] valid got %b want 1", name, k, ov); else n_pass++;
            if (od !== exp_d[k]) $display("FAIL %s[%0d] data got %h want %h", name, k, od, exp_d[k]); else n_pass++;
            if (ou !== exp_u[k]) $display("FAIL %s[%0d] underrun got %b want %b", name, k, ou, exp_u[k]); else n_pass++;
            if (ob !== exp_b[k]) $display("FAIL %s[%0d] busy got %b want %b", name, k, ob, exp_b[k]); else n_pass++;
        end
        if (!hold_next) s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        tick = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_checks += 5;
            if (sig_valid !== 1'b0) $display("FAIL reset valid got %b want 0", sig_valid); else n_pass++;
            if (sig_data !== 32'd0) $display("FAIL reset data got %h want 0", sig_data); else n_pass++;
            if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else n_pass++;
            if (underrun !== 1'b0) $display("FAIL reset underrun got %b want 0", underrun); else n_pass++;
            if (s_ready !== 1'b0) $display("FAIL reset s_ready got %b want 0", s_ready); else n_pass++;
        end
        tick = 1'b0;
        rst  = 1'b1;
    endtask

    task automatic test_basic_packet();
        pkt = {32'h0100_FF00, 32'h0200_FE00, 32'h0300_FD00, 32'h0400_FC00, 32'h0500_FB00};
        run_packet("basic", -1, 0, 1'b0);
    endtask

    task automatic test_underrun();
        pkt = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA};
        run_packet("underrun", 2, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        pkt = {32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        run_packet("b2b_first", -1, 0, 1'b1);
        pkt = {32'hB000_0001, 32'hB000_0002};
        run_packet("b2b_second", -1, 0, 1'b0);
    endtask

    task automatic test_single_sample();
        pkt = {32'h7FFF_8000};
        run_packet("single", -1, 0, 1'b0);
    endtask

    task automatic test_ramp();
        pkt = {32'h4000_C000, 32'h4000_C000, 32'h4000_C000,
               32'h4000_C000, 32'h4000_C000, 32'h4000_C000};
        run_packet("ramp", -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        logic rdy, ov, ou, ob, quiet;
        logic [31:0] od;
        pkt = {32'h0AAA_0555, 32'h0BBB_0666, 32'h0CCC_0777, 32'h0DDD_0888};
        s_valid = 1'b1;
        s_data  = pkt[0];
        s_last  = 1'b0;
        tick_cycle(1'b1, pkt[0], 1'b0, rdy, ov, od, ou, ob, quiet);
        tick_cycle(1'b1, pkt[1], 1'b0, rdy, ov, od, ou, ob, quiet);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks += 3;
        if (busy !== 1'b0) $display("FAIL midreset busy got %b want 0", busy); else n_pass++;
        if (sig_data !== 32'd0) $display("FAIL midreset data got %h want 0", sig_data); else n_pass++;
        if (sig_valid !== 1'b0) $display("FAIL midreset valid got %b want 0", sig_valid); else n_pass++;
        rst = 1'b1;
        run_packet("after_reset", -1, 0, 1'b0);
    endtask

    task automatic test_random();
        int len, sp, sn;
        bit hold;
        for (int p = 0; p < 4; p++) begin
            len = $urandom_range(1, 8);
            pkt = {};
            for (int i = 0; i < len; i++) pkt.push_back($urandom);
            sp   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            sn   = $urandom_range(1, 3);
            hold = (p != 3) && ($urandom_range(0, 1) == 1);
            run_packet("random", sp, sn, hold);
        end
    endtask

    initial begin
        rst     = 1'b0;
        tick    = 1'b0;
        s_valid = 1'b0;
        s_data  = 32'd0;
        s_last  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_packet();
        test_underrun();
        test_back_to_back();
        test_single_sample();
        test_ramp();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
